// File: rtl/count_monitor.sv
// Sequence monitor for a 4-bit counter: match/wrap pulses, saturating wrap count.
// Optional step checker (ERR state, seq_err) enabled by defining COUNT_MON_SEQ_CHECK_EN.
module count_monitor #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        q_in,
  input  logic [3:0]        match_val,
  input  logic              clr,
  output logic              match_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              wrap_sat,
  output logic              seq_err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_TRACK = 2'b01,
    ST_ERR   = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          prev_q, prev_d;
  logic                match_q, match_d;
  logic                wrap_q, wrap_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                wrap_sat_q, wrap_sat_d;
  logic                wrap_det, match_det;

`ifdef COUNT_MON_SEQ_CHECK_EN
  logic                seq_err_q, seq_err_d;
  logic [3:0]          prev_inc;
  logic                step_ok;

  assign prev_inc = prev_q + 4'd1;
  assign step_ok  = (q_in == prev_q) || (q_in == prev_inc);
`endif

  always_comb begin
    prev_d     = q_in;
    state_d    = state_q;
    match_d    = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
`ifdef COUNT_MON_SEQ_CHECK_EN
    seq_err_d  = seq_err_q;
`endif
    wrap_det   = (state_q != ST_INIT) && (prev_q == 4'hF) && (q_in == 4'h0);
    match_det  = (q_in == match_val) && ((prev_q != match_val) || (state_q == ST_INIT));

    if (clr) begin
      state_d    = ST_INIT;
      wrap_cnt_d = '0;
`ifdef COUNT_MON_SEQ_CHECK_EN
      seq_err_d  = 1'b0;
`endif
    end else begin
      match_d = match_det;
      wrap_d  = wrap_det;
      if (wrap_det && (wrap_cnt_q != '1)) begin
        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
      case (state_q)
        ST_INIT: state_d = ST_TRACK;
        ST_TRACK: begin
`ifdef COUNT_MON_SEQ_CHECK_EN
          if (!step_ok) begin
            state_d   = ST_ERR;
            seq_err_d = 1'b1;
          end
`endif
        end
        default: state_d = state_q;
      endcase
    end

    // Saturation flag tracks the next count so both update on the same edge.
    wrap_sat_d = (wrap_cnt_d == '1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      prev_q     <= '0;
      match_q    <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      wrap_sat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      wrap_sat_q <= wrap_sat_d;
    end
  end

`ifdef COUNT_MON_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  assign match_pulse = match_q;
  assign wrap_pulse  = wrap_q;
  assign wrap_cnt    = wrap_cnt_q;
  assign wrap_sat    = wrap_sat_q;
  assign state       = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: a rule-level model queues expected outputs per
// driven cycle, a monitor pops and compares after each edge. Two widths (8 and 2).
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] q_in = '0;
  logic [3:0] match_val = '0;
  logic       clr = 1'b0;

  logic       m8_match, m8_wrap, m8_sat, m8_seq;
  logic [7:0] m8_cnt;
  logic [1:0] m8_state;
  logic       m2_match, m2_wrap, m2_sat, m2_seq;
  logic [1:0] m2_cnt;
  logic [1:0] m2_state;

  count_monitor #(.WRAP_W(8)) dut8 (
    .clk(clk), .reset(reset), .q_in(q_in), .match_val(match_val), .clr(clr),
    .match_pulse(m8_match), .wrap_pulse(m8_wrap), .wrap_cnt(m8_cnt),
    .wrap_sat(m8_sat), .seq_err(m8_seq), .state(m8_state)
  );

  count_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .reset(reset), .q_in(q_in), .match_val(match_val), .clr(clr),
    .match_pulse(m2_match), .wrap_pulse(m2_wrap), .wrap_cnt(m2_cnt),
    .wrap_sat(m2_sat), .seq_err(m2_seq), .state(m2_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int match;
    int wrap;
    int wraps;
    int seq;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: 0 = INIT, 1 = TRACK, 2 = ERR; wraps counted without bound.
  int m_prev  = 0;
  int m_st    = 0;
  int m_wraps = 0;
  int m_seq   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat_cnt(input int wraps, input int max);
    return (wraps > max) ? max : wraps;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_st = 0; m_wraps = 0; m_seq = 0;
  endtask

  task automatic drive_now(input int q, input int mv, input int c);
    exp_t e;
    int   legal;
    q_in = 4'(q); match_val = 4'(mv); clr = c[0];
    if (c != 0) begin
      m_st = 0; m_wraps = 0; m_seq = 0;
      e.match = 0; e.wrap = 0;
    end else begin
      e.match = (q == mv && (m_prev != mv || m_st == 0)) ? 1 : 0;
      e.wrap  = (m_st != 0 && m_prev == 15 && q == 0) ? 1 : 0;
      if (e.wrap != 0 && m_wraps < 100000) m_wraps++;
      if (m_st == 0) begin
        m_st = 1;
      end else if (m_st == 1) begin
`ifdef COUNT_MON_SEQ_CHECK_EN
        legal = (q == m_prev || q == (m_prev + 1) % 16) ? 1 : 0;
        if (legal == 0) begin
          m_st = 2; m_seq = 1;
        end
`else
        legal = 1;
`endif
      end
    end
    m_prev  = q;
    e.wraps = m_wraps;
    e.seq   = m_seq;
    e.st    = m_st;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int q, input int mv, input int c);
    @(negedge clk);
    drive_now(q, mv, c);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_match8"}, m8_match, 0);
    chk({tag, "_wrap8"},  m8_wrap, 0);
    chk({tag, "_cnt8"},   m8_cnt, 0);
    chk({tag, "_sat8"},   m8_sat, 0);
    chk({tag, "_seq8"},   m8_seq, 0);
    chk({tag, "_state8"}, m8_state, 0);
    chk({tag, "_cnt2"},   m2_cnt, 0);
    chk({tag, "_sat2"},   m2_sat, 0);
    chk({tag, "_state2"}, m2_state, 0);
  endtask

  // Monitor: one expected entry per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("match_pulse", m8_match, e.match);
        chk("wrap_pulse",  m8_wrap,  e.wrap);
        chk("wrap_cnt8",   m8_cnt,   sat_cnt(e.wraps, 255));
        chk("wrap_sat8",   m8_sat,   (e.wraps >= 255) ? 1 : 0);
        chk("seq_err",     m8_seq,   e.seq);
        chk("state",       m8_state, e.st);
        chk("wrap_cnt2",   m2_cnt,   sat_cnt(e.wraps, 3));
        chk("wrap_sat2",   m2_sat,   (e.wraps >= 3) ? 1 : 0);
        chk("wrap_pulse2", m2_wrap,  e.wrap);
        chk("seq_err2",    m2_seq,   e.seq);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int q;
    int mv;
    int r;

    #2;
    check_all_zero("reset");

    // Release reset and count 0..15,0 with match_val=5.
    @(negedge clk);
    reset = 1'b1;
    drive_now(0, 5, 0);
    for (int i = 1; i < 16; i++) drive(i, 5, 0);
    drive(0, 5, 0);

    // Hold at 7 with match_val=7, then step to 8.
    for (int i = 0; i < 4; i++) drive(7, 7, 0);
    drive(8, 7, 0);

    // Skip 3->9, keep counting through a wrap, then clr.
    drive(3, 0, 0);
    drive(9, 0, 0);
    for (int i = 10; i < 16; i++) drive(i, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(2, 0, 1);
    drive(3, 0, 0);
    drive(4, 0, 0);

    // Five full sequences after a clr: WRAP_W=2 instance saturates at 3.
    drive(0, 9, 1);
    for (int s = 0; s < 5; s++)
      for (int i = (s == 0) ? 1 : 0; i < 16; i++) drive(i, 9, 0);
    drive(0, 9, 0);

    // clr on the edge that samples 15->0.
    drive(14, 2, 0);
    drive(15, 2, 0);
    drive(0, 2, 1);
    drive(1, 2, 0);

    // Build up two wraps and a sequence error, then reset between edges.
    drive(0, 4, 1);
    for (int s = 0; s < 2; s++)
      for (int i = (s == 0) ? 1 : 0; i < 16; i++) drive(i, 4, 0);
    drive(0, 4, 0);
    drive(5, 4, 0);
    drive(6, 4, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_now(6, 6, 0);
    for (int i = 7; i < 16; i++) drive(i, 6, 0);
    drive(0, 6, 0);

    // Randomized counting with occasional holds, jumps, clr and match_val changes.
    q  = 0;
    mv = 3;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 10) q = (q + 1) % 16;
      else if (r < 14) q = q;
      else q = int'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) mv = int'($urandom_range(0, 15));
      drive(q, mv, ($urandom_range(0, 39) == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
